ram_loader: RTL

RAM_LOADER -- requirements
Module: ram_loader

---
 rtl/ram_loader_pkg.sv | 10 +
 rtl/ram_sync_wr.sv | 28 ++
 rtl/ram_loader.sv | 109 ++++++++++
 3 files changed

// File: rtl/ram_loader_pkg.sv
// Shared definitions for the RAM loader: FSM state encoding used by RTL and bench.
package ram_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : ram_loader_pkg

// File: rtl/ram_sync_wr.sv
// Simple RAM: one synchronous write port, one combinational (zero-latency) read port.
// Contents are deliberately not reset so data survives a reset of the loader.
module ram_sync_wr #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int ADDRW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ADDRW-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [ADDRW-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write the addressed word on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Asynchronous read: old word before a write edge, new word after it.
    assign rdata = r_mem[raddr];

endmodule : ram_sync_wr

// File: rtl/ram_loader.sv
// Streams DEPTH words into a RAM starting at address 0 after each start.
// Valid/ready input handshake, abort to cancel, done when every word was written.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int ADDRW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [ADDRW:0]   count,
    input  logic [ADDRW-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    state_t           r_state;
    state_t           w_state_next;
    logic [ADDRW-1:0] r_wr_addr;
    logic [ADDRW:0]   r_count;
    logic             r_done;

    logic             w_load;
    logic             w_start_ok;
    logic             w_xfer;
    logic             w_last;

    // Ready depends only on the state register, never on the inputs.
    assign w_load     = (r_state == LOAD);
    // A start is honoured outside LOAD only, and abort always beats it.
    assign w_start_ok = !w_load && start && !abort;
    // Abort suppresses any transfer offered on the same edge.
    assign w_xfer     = w_load && in_valid && !abort;
    assign w_last     = (r_wr_addr == ADDRW'(DEPTH - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; DONE reacts to start exactly like IDLE.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE, DONE: begin
                if (w_start_ok) begin
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    w_state_next = IDLE;
                end else if (w_xfer && w_last) begin
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Write address, word count and done flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_addr <= '0;
            r_count   <= '0;
            r_done    <= 1'b0;
        end else if (w_start_ok) begin
            r_wr_addr <= '0;
            r_count   <= '0;
            r_done    <= 1'b0;
        end else if (w_xfer) begin
            r_wr_addr <= r_wr_addr + ADDRW'(1);
            r_count   <= r_count + (ADDRW + 1)'(1);
            if (w_last) begin
                r_done <= 1'b1;
            end
        end
    end

    ram_sync_wr #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDRW (ADDRW)
    ) u_ram (
        .clk   (clk),
        .we    (w_xfer),
        .waddr (r_wr_addr),
        .wdata (in_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign in_ready = w_load;
    assign busy     = w_load;
    assign done     = r_done;
    assign count    = r_count;

endmodule : ram_loader
